// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL bit layout and default placement of the timer block.
package mmio_timer_pkg;

    localparam logic [14:0] DEFAULT_BASE_ADDR = 15'd24577;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_RELOAD = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_DIR    = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_PS_LSB = 4;
    localparam int CTRL_W      = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVR   = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/COUNT/RELOAD/STATUS registers, tick gating and match/overrun tracking.
// CPU writes land on the next edge; a CTRL or COUNT write suppresses that cycle's count step.
module timer_channel
    import mmio_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WIDTH-1:0]  prescaler_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              wr_ctrl_i,
    input  logic              wr_count_i,
    input  logic              wr_reload_i,
    input  logic              wr_status_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [WIDTH-1:0]  count_o,
    output logic [WIDTH-1:0]  reload_o,
    output logic [1:0]        status_o,
    output logic              irq_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [1:0]        status_q, status_d;
    logic              irq_q;

    logic [3:0]        ps;
    logic [WIDTH-1:0]  ps_mask;
    logic              tick, step, dn, evt;

    always_comb begin
        ps      = ctrl_q[CTRL_PS_LSB +: 4];
        // PS=0 yields an empty mask, so every cycle qualifies.
        ps_mask = (WIDTH'(1) << ps) - WIDTH'(1);
        tick    = ctrl_q[CTRL_EN] && ((prescaler_i & ps_mask) == ps_mask);
        step    = tick && !wr_ctrl_i && !wr_count_i;
        dn      = ctrl_q[CTRL_DIR];
        evt     = step && (dn ? (count_q == '0) : (count_q == reload_q));

        ctrl_d   = ctrl_q;
        count_d  = count_q;
        reload_d = reload_q;
        status_d = status_q & ~({2{wr_status_i}} & wdata_i[1:0]);

        if (step) begin
            if (evt) begin
                if (ctrl_q[CTRL_AUTO]) count_d = dn ? reload_q : '0;
                else                   ctrl_d[CTRL_EN] = 1'b0;
            end else begin
                count_d = dn ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
            end
        end

        if (evt) begin
            status_d[STATUS_MATCH] = 1'b1;
            if (status_q[STATUS_MATCH]) status_d[STATUS_OVR] = 1'b1;
        end

        if (wr_ctrl_i)   ctrl_d   = wdata_i[CTRL_W-1:0];
        if (wr_count_i)  count_d  = wdata_i;
        if (wr_reload_i) reload_d = wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            reload_q <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            status_q <= status_d;
            irq_q    <= status_q[STATUS_MATCH] & ctrl_q[CTRL_IRQ_EN];
        end
    end

    assign ctrl_o   = ctrl_q;
    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped multi-channel timer: address decode, shared prescaler and combinational read mux.
// Reads are same-cycle and side-effect free; writes commit on the next rising edge.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          CHANNELS  = 4,
    parameter logic [14:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [14:0]         addressM,
    input  logic [WIDTH-1:0]    outM,
    input  logic                writeM,
    output logic [WIDTH-1:0]    rdata,
    output logic                hit,
    output logic [CHANNELS-1:0] irq
);

    localparam int          CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] SPAN = 16'(4 * CHANNELS);

    logic [14:0]      offset;
    logic [CH_W-1:0]  ch_sel;
    reg_e             reg_sel;
    logic [WIDTH-1:0] prescaler_q;

    logic [CTRL_W-1:0] ctrl_a   [CHANNELS];
    logic [WIDTH-1:0]  count_a  [CHANNELS];
    logic [WIDTH-1:0]  reload_a [CHANNELS];
    logic [1:0]        status_a [CHANNELS];

    assign offset  = addressM - BASE_ADDR;
    assign hit     = (addressM >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign ch_sel  = offset[2 +: CH_W];
    assign reg_sel = reg_e'(offset[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prescaler_q <= '0;
        else        prescaler_q <= prescaler_q + WIDTH'(1);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic wr_sel;
        assign wr_sel = writeM && hit && (ch_sel == CH_W'(g));

        timer_channel #(.WIDTH(WIDTH)) u_channel (
            .clk_i       (clk),
            .rst_ni      (reset),
            .prescaler_i (prescaler_q),
            .wdata_i     (outM),
            .wr_ctrl_i   (wr_sel && (reg_sel == REG_CTRL)),
            .wr_count_i  (wr_sel && (reg_sel == REG_COUNT)),
            .wr_reload_i (wr_sel && (reg_sel == REG_RELOAD)),
            .wr_status_i (wr_sel && (reg_sel == REG_STATUS)),
            .ctrl_o      (ctrl_a[g]),
            .count_o     (count_a[g]),
            .reload_o    (reload_a[g]),
            .status_o    (status_a[g]),
            .irq_o       (irq[g])
        );
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                REG_CTRL:   rdata = WIDTH'(ctrl_a[ch_sel]);
                REG_COUNT:  rdata = count_a[ch_sel];
                REG_RELOAD: rdata = reload_a[ch_sel];
                REG_STATUS: rdata = WIDTH'(status_a[ch_sel]);
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed scenarios plus randomized register traffic, all checked against a cycle-level register model.
module tb_mmio_timer;

    localparam int          W    = 16;
    localparam int          NCH  = 4;
    localparam logic [14:0] BASE = 15'd24577;
    localparam int          MSK  = 32'hFFFF;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [14:0]    addressM = '0;
    logic [W-1:0]   outM = '0;
    logic           writeM = 1'b0;
    logic [W-1:0]   rdata;
    logic           hit;
    logic [NCH-1:0] irq;

    mmio_timer #(.WIDTH(W), .CHANNELS(NCH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .addressM (addressM),
        .outM     (outM),
        .writeM   (writeM),
        .rdata    (rdata),
        .hit      (hit),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_ctrl [NCH];
    int m_cnt  [NCH];
    int m_rel  [NCH];
    int m_st   [NCH];
    int m_irq  [NCH];
    int m_pre;

    logic [W-1:0]   last_rd;
    logic           last_hit;
    logic [NCH-1:0] last_irq = '0;
    logic [NCH-1:0] prev_irq = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_hit(input logic [14:0] a);
        return (int'(a) >= int'(BASE) && int'(a) < int'(BASE) + 4 * NCH) ? 1 : 0;
    endfunction

    function automatic int m_read(input logic [14:0] a);
        int off;
        if (m_hit(a) == 0) return 0;
        off = int'(a) - int'(BASE);
        case (off % 4)
            0:       return m_ctrl[off / 4];
            1:       return m_cnt[off / 4];
            2:       return m_rel[off / 4];
            default: return m_st[off / 4];
        endcase
    endfunction

    function automatic logic [NCH-1:0] m_irq_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_irq[i] != 0);
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_ctrl[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_st[i] = 0; m_irq[i] = 0;
        end
        m_pre = 0;
    endtask

    // Advance the model by one rising edge given the bus inputs present before it.
    task automatic m_step(input logic [14:0] a, input logic [W-1:0] d, input logic w);
        int off, wch, wreg, dv;
        int n_ctrl [NCH];
        int n_cnt  [NCH];
        int n_rel  [NCH];
        int n_st   [NCH];
        int n_irq  [NCH];
        bit we;
        we  = w && (m_hit(a) != 0);
        off = int'(a) - int'(BASE);
        wch = we ? off / 4 : -1;
        wreg = we ? off % 4 : -1;
        dv  = int'(d);
        for (int i = 0; i < NCH; i++) begin
            int ps, pm;
            bit tick, dn, ev, wc, wn, wr, ws;
            wc = (wch == i) && (wreg == 0);
            wn = (wch == i) && (wreg == 1);
            wr = (wch == i) && (wreg == 2);
            ws = (wch == i) && (wreg == 3);
            ps = (m_ctrl[i] >> 4) & 15;
            pm = (1 << ps) - 1;
            tick = ((m_ctrl[i] & 1) != 0) && ((m_pre & pm) == pm);
            dn = ((m_ctrl[i] >> 2) & 1) != 0;
            ev = 1'b0;
            n_ctrl[i] = m_ctrl[i]; n_cnt[i] = m_cnt[i]; n_rel[i] = m_rel[i]; n_st[i] = m_st[i];
            if (tick && !wc && !wn) begin
                if (!dn) begin
                    if (m_cnt[i] == m_rel[i]) ev = 1'b1;
                    else n_cnt[i] = (m_cnt[i] + 1) & MSK;
                end else begin
                    if (m_cnt[i] == 0) ev = 1'b1;
                    else n_cnt[i] = (m_cnt[i] - 1) & MSK;
                end
                if (ev) begin
                    if ((m_ctrl[i] & 2) != 0) n_cnt[i] = dn ? m_rel[i] : 0;
                    else n_ctrl[i] = m_ctrl[i] & ~1;
                end
            end
            if (ws) n_st[i] = m_st[i] & ~(dv & 3);
            if (ev) begin
                n_st[i] = n_st[i] | 1;
                if ((m_st[i] & 1) != 0) n_st[i] = n_st[i] | 2;
            end
            if (wc) n_ctrl[i] = dv & 8'hFF;
            if (wn) n_cnt[i] = dv;
            if (wr) n_rel[i] = dv;
            n_irq[i] = ((m_st[i] & 1) != 0 && (m_ctrl[i] & 8) != 0) ? 1 : 0;
        end
        for (int i = 0; i < NCH; i++) begin
            m_ctrl[i] = n_ctrl[i]; m_cnt[i] = n_cnt[i]; m_rel[i] = n_rel[i];
            m_st[i] = n_st[i]; m_irq[i] = n_irq[i];
        end
        m_pre = (m_pre + 1) & MSK;
    endtask

    // One bus cycle: drive, check combinational read, clock, check registered irq.
    task automatic do_cycle(input logic [14:0] a, input logic [W-1:0] d, input logic w);
        addressM = a; outM = d; writeM = w;
        #1;
        last_rd = rdata; last_hit = hit;
        check("hit", hit, m_hit(a));
        check("rdata", rdata, m_read(a));
        @(posedge clk);
        m_step(a, d, w);
        #1;
        prev_irq = last_irq;
        last_irq = irq;
        check("irq", irq, m_irq_vec());
        writeM = 1'b0;
    endtask

    initial begin
        logic [14:0] a;
        logic [W-1:0] d;
        int t1, t2, off;

        m_reset();
        #2;
        for (int k = 0; k < 20; k++) begin
            addressM = BASE + 15'(k) - 15'd2;
            #1;
            check("rst_rdata", rdata, 0);
            check("rst_hit", hit, m_hit(addressM));
        end
        check("rst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b1;

        // ch0 up, auto-reload, RELOAD=3
        do_cycle(BASE + 15'd2, 16'd3, 1'b1);
        do_cycle(BASE + 15'd0, 16'h3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            do_cycle(BASE + 15'd1, '0, 1'b0);
            check("up_count", last_rd, (k == 4) ? 0 : k);
        end
        do_cycle(BASE + 15'd3, '0, 1'b0);
        check("up_match", last_rd, 1);
        do_cycle(BASE + 15'd0, 16'h0, 1'b1);
        do_cycle(BASE + 15'd3, 16'h3, 1'b1);

        // ch1 down, one-shot, from 5
        do_cycle(BASE + 15'd6, 16'd5, 1'b1);
        do_cycle(BASE + 15'd5, 16'd5, 1'b1);
        do_cycle(BASE + 15'd4, 16'h5, 1'b1);
        for (int k = 0; k < 5; k++) do_cycle(BASE + 15'd1, '0, 1'b0);
        do_cycle(BASE + 15'd7, '0, 1'b0);
        check("dn_pre_event", last_rd, 0);
        do_cycle(BASE + 15'd4, '0, 1'b0);
        check("dn_ctrl", last_rd, 16'h4);
        do_cycle(BASE + 15'd5, '0, 1'b0);
        check("dn_count", last_rd, 0);
        do_cycle(BASE + 15'd7, '0, 1'b0);
        check("dn_status", last_rd, 1);

        // ch2 PS=2, irq_en, one-shot up with RELOAD=1
        do_cycle(BASE + 15'd10, 16'd1, 1'b1);
        do_cycle(BASE + 15'd8, 16'h29, 1'b1);
        t1 = -1; t2 = -1;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            do_cycle((t1 < 0) ? BASE + 15'd9 : BASE + 15'd11, '0, 1'b0);
            if (t1 < 0) begin
                if (last_rd == 16'd1) t1 = k;
            end else if (last_rd == 16'd1) begin
                t2 = k;
                check("ps_irq_before", prev_irq[2], 0);
                check("ps_irq_after", last_irq[2], 1);
            end
        end
        check("ps_tick_spacing", t2 - t1, 4);
        do_cycle(BASE + 15'd8, 16'h0, 1'b1);
        do_cycle(BASE + 15'd11, 16'h3, 1'b1);

        // ch3 period 3: clear coinciding with an event, then an unacknowledged second event
        do_cycle(BASE + 15'd14, 16'd2, 1'b1);
        do_cycle(BASE + 15'd12, 16'h3, 1'b1);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd15, 16'h1, 1'b1);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd15, 16'h1, 1'b1);
        do_cycle(BASE + 15'd15, '0, 1'b0);
        check("clr_vs_event", last_rd, 1);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        do_cycle(BASE + 15'd15, '0, 1'b0);
        check("overrun", last_rd, 3);
        do_cycle(BASE + 15'd12, 16'h0, 1'b1);

        // up-count wrap from above RELOAD
        do_cycle(BASE + 15'd13, 16'hFFFE, 1'b1);
        do_cycle(BASE + 15'd12, 16'h3, 1'b1);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        check("wrap_a", last_rd, 16'hFFFE);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        check("wrap_b", last_rd, 16'hFFFF);
        do_cycle(BASE + 15'd13, '0, 1'b0);
        check("wrap_c", last_rd, 0);
        do_cycle(BASE + 15'd12, 16'h0, 1'b1);

        // COUNT write on a tick cycle wins over the step
        do_cycle(BASE + 15'd2, 16'h20, 1'b1);
        do_cycle(BASE + 15'd0, 16'h3, 1'b1);
        do_cycle(BASE + 15'd1, '0, 1'b0);
        do_cycle(BASE + 15'd1, 16'h10, 1'b1);
        do_cycle(BASE + 15'd1, '0, 1'b0);
        check("cnt_wr_prio", last_rd, 16'h10);
        do_cycle(BASE + 15'd1, '0, 1'b0);
        check("cnt_after_wr", last_rd, 16'h11);

        // outside the window
        do_cycle(BASE + 15'd16, 16'hFFFF, 1'b1);
        check("oob_hit", last_hit, 0);
        check("oob_rdata", last_rd, 0);
        do_cycle(BASE - 15'd1, '0, 1'b0);
        check("below_hit", last_hit, 0);

        // reset pulse while ch0 is counting
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        for (int k = 0; k < 16; k++) begin
            addressM = BASE + 15'(k);
            #1;
            check("midrst_rdata", rdata, 0);
        end
        check("midrst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b1;
        do_cycle(BASE + 15'd3, '0, 1'b0);
        check("post_rst_status", last_rd, 0);
        do_cycle(BASE + 15'd1, '0, 1'b0);
        check("post_rst_count", last_rd, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            a = BASE + 15'($urandom_range(0, 19)) - 15'd2;
            off = int'(a) - int'(BASE);
            if ($urandom_range(0, 9) < 6) begin
                do_cycle(a, W'($urandom), 1'b0);
            end else begin
                d = W'($urandom);
                if (off >= 0 && off < 4 * NCH) begin
                    case (off % 4)
                        0: d = W'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
                        1: d = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
                        2: d = W'($urandom_range(0, 9));
                        default: d = W'($urandom_range(0, 3));
                    endcase
                end
                do_cycle(a, d, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data and counter width.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning the number of timer channels (1, 2, 4 or 8).
REQ-003 SHALL have parameter BASE_ADDR, default 15'd24577, meaning the first mapped word address, directly above the keyboard word.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port addressM, input, 15 bits, the CPU data address.
REQ-007 SHALL have port outM, input, WIDTH bits, the CPU write data.
REQ-008 SHALL have port writeM, input, 1 bit, the CPU write strobe.
REQ-009 SHALL have port rdata, output, WIDTH bits, the read data for the CPU inM mux.
REQ-010 SHALL have port hit, output, 1 bit, high when addressM is inside the mapped window.
REQ-011 SHALL have port irq, output, CHANNELS bits, one interrupt line per channel.

Function
REQ-012 SHALL map 4 words per channel from BASE_ADDR: offset = addressM-BASE_ADDR; ch = offset[..:2]; reg = offset[1:0] (0 CTRL, 1 COUNT, 2 RELOAD, 3 STATUS).
REQ-013 SHALL drive hit=1 only for BASE_ADDR <= addressM < BASE_ADDR+4*CHANNELS; otherwise hit=0 and rdata=0.
REQ-014 SHALL return rdata combinationally in the same cycle from the addressed register; reads have no side effects.
REQ-015 SHALL commit writes (writeM & hit) at the next rising edge.
REQ-016 SHALL define CTRL as: [0] enable, [1] auto-reload, [2] direction (0 up, 1 down), [3] irq_en, [7:4] prescale exponent PS; upper bits read 0.
REQ-017 SHALL run a shared free-running WIDTH-bit prescaler; a channel tick occurs when enable=1 and either PS=0 or prescaler[PS-1:0] is all ones.
REQ-018 SHALL handle an up-mode tick as follows: if COUNT==RELOAD, raise an event; otherwise COUNT+1.
REQ-019 SHALL handle a down-mode tick as follows: if COUNT==0, raise an event; otherwise COUNT-1.
REQ-020 SHALL, on an event with auto-reload=1, load COUNT with 0 (up mode) or RELOAD (down mode); the period is therefore RELOAD+1 ticks.
REQ-021 SHALL, on an event with auto-reload=0, hold COUNT and clear enable (one-shot).
REQ-022 SHALL, on an event, set STATUS[0] (match, sticky); if STATUS[0] is already 1, it SHALL also set STATUS[1] (overrun, sticky).
REQ-023 SHALL clear STATUS bits on write-1; an event in the same cycle takes priority over the clear.
REQ-024 SHALL give a CPU write to COUNT or CTRL priority over the tick in the same cycle; no count step occurs that cycle.
REQ-025 SHALL register irq[ch] as STATUS[0] & irq_en, so it is valid one cycle after the event edge.
REQ-026 SHALL make all arithmetic modulo 2^WIDTH; COUNT > RELOAD in up mode wraps through 0 before a match.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear all CTRL, COUNT, RELOAD, STATUS, the prescaler and irq to 0; rdata then follows decode of zeroed registers.
REQ-028 SHALL, on reset assertion mid-count, lose channel state; no event is generated on release.

Structure
REQ-029 SHALL place register offsets, CTRL bit indices and the default BASE_ADDR in package mmio_timer_pkg.
REQ-030 SHALL implement one sub-module, timer_channel, instantiated CHANNELS times; mmio_timer holds the decode, prescaler and read mux.

Verification
REQ-031 SHALL cover: ch0 RELOAD=3, CTRL=0x3 (up, auto, PS=0) -> COUNT 0,1,2,3,0…; STATUS[0]=1 after the 4th tick.
REQ-032 SHALL cover: ch1 RELOAD=5, COUNT=5, CTRL=0x5 (down, one-shot) -> event after 6 ticks, enable reads 0, COUNT holds 0.
REQ-033 SHALL cover: ch2 CTRL=0x29 (PS=2, irq_en) with RELOAD=1 -> tick every 4 clk; irq[2] high 1 cycle after the event.
REQ-034 SHALL cover: a write of STATUS=1 coinciding with an event -> STATUS[0] stays 1; a second unacknowledged event -> STATUS=3.
REQ-035 SHALL cover: a write of COUNT=0x10 on a tick cycle -> COUNT reads 0x10 next cycle, not 0x11.
REQ-036 SHALL cover: addressM=BASE_ADDR+16 with CHANNELS=4 -> hit=0, rdata=0; reset pulsed mid-count -> all registers read 0.
